dht11_responder: RTL
====================

DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 Parameter T_START_MIN, 500000, minimum host start-low width in cycles (10 ms at 50 MHz).
REQ-002 Parameter T_RESP_DLY, 1500, delay from host release to the response-low phase (30 us).
REQ-003 Parameter T_80US, 4000, width of the response-low and response-high phases.
REQ-004 Parameter T_50US, 2500, low preamble before each data bit and before the end phase.
REQ-005 Parameter T_BIT0 and T_BIT1, 1300 and 3500, released-high width for data 0 and data 1 (26 us and 70 us).
REQ-006 Port i_Clock, input, 1, 50 MHz system clock; the block uses one clock only.
REQ-007 Port i_Rst_n, input, 1, reset; asynchronous and active-low.
REQ-008 Port i_En, input, 1, enable; low aborts any activity and holds the block in IDLE.
REQ-009 Port i_Load, input, 1, single-cycle strobe that captures the four data bytes into the shadow register.
REQ-010 Port i_Humid_Int, i_Humid_Dec, i_Temp_Int and i_Temp_Dec, input, 8 each, measurement bytes.
REQ-011 Port io_Dht_Data, inout, 1, single-wire bus; the block either drives 0 or leaves it at high impedance (open-drain), and an external pull-up provides the high level.
REQ-012 Port o_Busy, output, 1, high from start-pulse qualification until the end of the frame.
REQ-013 Port o_Frame_Done, output, 1, one-cycle pulse when a complete frame has been sent.

Function
REQ-014 The block SHALL pass io_Dht_Data through a 2-flop synchronizer (reset value 1); all bus decisions use the synchronized value.
REQ-015 i_Load SHALL copy the four input bytes into a shadow register in any state.
REQ-016 At the RESP_DLY entry edge, the block SHALL latch a 40-bit frame in this order, MSB first: shadow humid_int, humid_dec, temp_int, temp_dec, checksum.
- checksum = sum of the four bytes mod 256, carry discarded.
- An i_Load arriving mid-frame SHALL NOT alter the frame in flight.
REQ-017 IDLE: bus released, counter 0; synchronized low -> START_LOW.
REQ-018 START_LOW: count cycles while the line is low; on high:
- if count >= T_START_MIN -> RESP_DLY, o_Busy=1;
- otherwise -> IDLE (glitch or short pulse ignored, no response).
- The counter SHALL saturate and not wrap.
REQ-019 RESP_DLY: bus released for T_RESP_DLY cycles -> RESP_LOW.
REQ-020 RESP_LOW: drive 0 for T_80US cycles -> RESP_HIGH.
REQ-021 RESP_HIGH: release for T_80US cycles -> BIT_LOW with bit index 0.
REQ-022 BIT_LOW: drive 0 for T_50US cycles -> BIT_HIGH.
REQ-023 BIT_HIGH: release for T_BIT1 cycles if the current bit is 1, else T_BIT0 cycles.
- index < 39 -> increment index, go to BIT_LOW.
- index = 39 -> END_LOW.
REQ-024 END_LOW: drive 0 for T_50US cycles, then release, pulse o_Frame_Done, set o_Busy=0, go to IDLE.
REQ-025 Every phase count SHALL be exact: a phase lasting N cycles occupies exactly N clock cycles.
REQ-026 A low level sampled during a released phase (contention) SHALL be ignored; the frame continues.
REQ-027 i_En=0 in any state SHALL release the bus within 1 cycle, clear o_Busy and force IDLE without pulsing o_Frame_Done.
REQ-028 A new start pulse SHALL be recognized only from IDLE.

Reset
REQ-029 Asserting i_Rst_n=0 SHALL immediately, asynchronously:
- release the bus;
- force IDLE;
- clear the counter, index, o_Busy and o_Frame_Done;
- clear the shadow and frame registers to 0;
- set the synchronizer flops to 1.
REQ-030 Reset asserted mid-frame SHALL truncate the frame with no o_Frame_Done pulse; after release, the block waits for a new start pulse.

Verification
REQ-031 Shadow 0x37,0x00,0x19,0x05 loaded, host low 900001 cycles then released -> 30 us release, 80/80 us response, 40 bits 00110111 00000000 00011001 00000101 01010101, END_LOW, one o_Frame_Done pulse.
REQ-032 Bytes 0xFF,0xFF,0xFF,0xFF -> checksum 0xFC, with bit-1 high phases of 3500 cycles and bit-0 high phases of 1300 cycles.
REQ-033 Host low pulse of 400000 cycles -> bus never driven, o_Busy stays 0.
REQ-034 i_Load of new bytes during bit 10 -> current frame unchanged; next frame carries the new bytes.
REQ-035 i_Rst_n=0 during RESP_LOW, then i_En=0 during bit 20 of a later frame -> bus released immediately in both cases, no o_Frame_Done.
REQ-036 Loop this block with the host reader -> host sensor data equals the loaded frame, and the host reports no error.

Source files
------------

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse on the open-drain single-wire bus
// with the response preamble and a 40-bit humidity/temperature frame.
module dht11_responder #(
    parameter int unsigned T_START_MIN = 500000,
    parameter int unsigned T_RESP_DLY  = 1500,
    parameter int unsigned T_80US      = 4000,
    parameter int unsigned T_50US      = 2500,
    parameter int unsigned T_BIT0      = 1300,
    parameter int unsigned T_BIT1      = 3500
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_En,
    input  logic       i_Load,
    input  logic [7:0] i_Humid_Int,
    input  logic [7:0] i_Humid_Dec,
    input  logic [7:0] i_Temp_Int,
    input  logic [7:0] i_Temp_Dec,
    inout  wire        io_Dht_Data,
    output logic       o_Busy,
    output logic       o_Frame_Done
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned T_MAX = max2(max2(max2(T_START_MIN, T_RESP_DLY), max2(T_80US, T_50US)),
                                         max2(T_BIT0, T_BIT1));
    localparam int unsigned CNT_W   = $clog2(T_MAX + 1);
    localparam int unsigned FRAME_W = 40;
    localparam int unsigned IDX_W   = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_LOW,
        S_RESP_DLY,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_END_LOW
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [FRAME_W-1:0]   r_frame;
    logic [31:0]          r_shadow;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_drive_low;
    logic [1:0]           r_drv_hist;

    logic [7:0]           w_checksum;
    logic [CNT_W-1:0]     w_bit_last;
    logic                 w_bus_free;

    // Open-drain: only ever pull low, the external pull-up supplies the high level.
    assign io_Dht_Data = r_drive_low ? 1'b0 : 1'bz;

    assign w_checksum = 8'(r_shadow[31:24] + r_shadow[23:16] + r_shadow[15:8] + r_shadow[7:0]);
    assign w_bit_last = r_frame[FRAME_W-1] ? CNT_W'(T_BIT1 - 1) : CNT_W'(T_BIT0 - 1);
    // Our own low drive echoes through the synchronizer for two cycles after release.
    assign w_bus_free = !r_drive_low && (r_drv_hist == 2'b00);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_drv_hist <= 2'b00;
            r_shadow   <= '0;
        end else begin
            r_sync1    <= io_Dht_Data;
            r_sync2    <= r_sync1;
            r_drv_hist <= {r_drv_hist[0], r_drive_low};
            if (i_Load) begin
                r_shadow <= {i_Humid_Int, i_Humid_Dec, i_Temp_Int, i_Temp_Dec};
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_frame      <= '0;
            r_drive_low  <= 1'b0;
            o_Busy       <= 1'b0;
            o_Frame_Done <= 1'b0;
        end else if (!i_En) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_drive_low  <= 1'b0;
            o_Busy       <= 1'b0;
            o_Frame_Done <= 1'b0;
        end else begin
            o_Frame_Done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_sync2 && w_bus_free) begin
                        r_state <= S_START_LOW;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_START_LOW: begin
                    if (r_sync2) begin
                        r_cnt <= '0;
                        if (r_cnt >= CNT_W'(T_START_MIN)) begin
                            r_state <= S_RESP_DLY;
                            o_Busy  <= 1'b1;
                            r_frame <= {r_shadow, w_checksum};
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP_DLY: begin
                    if (r_cnt == CNT_W'(T_RESP_DLY - 1)) begin
                        r_state     <= S_RESP_LOW;
                        r_cnt       <= '0;
                        r_drive_low <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP_LOW: begin
                    if (r_cnt == CNT_W'(T_80US - 1)) begin
                        r_state     <= S_RESP_HIGH;
                        r_cnt       <= '0;
                        r_drive_low <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP_HIGH: begin
                    if (r_cnt == CNT_W'(T_80US - 1)) begin
                        r_state     <= S_BIT_LOW;
                        r_cnt       <= '0;
                        r_idx       <= '0;
                        r_drive_low <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_BIT_LOW: begin
                    if (r_cnt == CNT_W'(T_50US - 1)) begin
                        r_state     <= S_BIT_HIGH;
                        r_cnt       <= '0;
                        r_drive_low <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_BIT_HIGH: begin
                    if (r_cnt == w_bit_last) begin
                        r_cnt       <= '0;
                        r_drive_low <= 1'b1;
                        r_frame     <= {r_frame[FRAME_W-2:0], 1'b0};
                        if (r_idx == IDX_W'(FRAME_W - 1)) begin
                            r_state <= S_END_LOW;
                        end else begin
                            r_state <= S_BIT_LOW;
                            r_idx   <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_END_LOW: begin
                    if (r_cnt == CNT_W'(T_50US - 1)) begin
                        r_state      <= S_IDLE;
                        r_cnt        <= '0;
                        r_drive_low  <= 1'b0;
                        o_Busy       <= 1'b0;
                        o_Frame_Done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_drive_low <= 1'b0;
                    o_Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
